issue_scheduler: RTL and testbench
==================================

# issue_scheduler

Wakeup/select scheduler that directly feeds the instruction queue. It allocates free queue slots to dispatching instructions and keeps a per-slot copy of source physical tags and ready bits. It snoops the writeback tag broadcast to wake sources, and each cycle selects one fully ready slot, driving the queue read address and read enable. Everything downstream of dispatch and upstream of register read is gated by this block.

## Interface
- ENTRIES, 64, queue slots; must equal instruction queue ENTRIES
- ADDR_WIDTH, $clog2(ENTRIES), slot index width
- PHYS_COUNT, 128, physical registers
- PHYS_ADDR_WIDTH, $clog2(PHYS_COUNT), physical tag width
- WAKEUP_PORTS, 2, writeback tag broadcast ports
---
- clk  in  1  single clock, rising edge
- async_rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  all state updates (including flush) occur only when high
- flush  in  1  discard all entries
- alloc_valid  in  1  dispatch presents an instruction
- alloc_src_addr  in  PHYS_ADDR_WIDTH x2  source tags
- alloc_src_valid  in  1 x2  source used
- alloc_src_ready  in  1 x2  source already ready per scoreboard
- alloc_ready  out  1  free slot exists (combinational)
- alloc_addr  out  ADDR_WIDTH  slot granted; drives queue wr address (combinational)
- wakeup_valid  in  1 x WAKEUP_PORTS  broadcast valid
- wakeup_tag  in  PHYS_ADDR_WIDTH x WAKEUP_PORTS  produced tag
- issue_stall  in  1  downstream back-pressure
- issue_valid  out  1  registered; drives queue rd_en
- issue_addr  out  ADDR_WIDTH  registered; drives queue rd address
- occupancy  out  ADDR_WIDTH+1  valid slots (registered)

## Operation
- Per slot: valid, tag[2], rdy[2]. Slot is eligible when valid and rdy[0] and rdy[1].
- Allocation: alloc_addr = lowest-index non-valid slot; alloc_ready = any non-valid slot. Fire = alloc_valid & alloc_ready & clk_en & !flush. On fire, write the slot: valid=1, tag=alloc_src_addr, rdy[i] = !alloc_src_valid[i] | alloc_src_ready[i] | (tag hit on any wakeup port this cycle). The same-cycle wakeup bypass is mandatory.
- Wakeup: each cycle, any valid slot whose tag[i] equals a valid wakeup_tag sets rdy[i]=1. Sources already ready are unaffected. Duplicate hits are harmless.
- Select: among eligible slots, choose per Configuration. If !issue_stall and a winner exists: issue_valid<=1, issue_addr<=winner, winner valid<=0. Otherwise issue_valid<=0 and issue_addr holds.
- A slot issued at an edge is free for allocation in the following cycle, never the same cycle. Allocation and issue in one cycle always target different slots.
- occupancy: +1 on fire, -1 on issue, unchanged if both occur. Never exceeds ENTRIES.
- flush (with clk_en): all valid<=0, issue_valid<=0, occupancy<=0. Any alloc or wakeup in that cycle is ignored. Flush has priority over all other events.
- Reset: all valid=0, rdy=0, tags=0, issue_valid=0, issue_addr=0, occupancy=0. This gives alloc_ready=1 and alloc_addr=0.
- clk_en low: no state change, and issue_valid/issue_addr hold their values.

## Timing
- Alloc fire at edge N with both sources ready: eligible in cycle N+1, issue_valid high in cycle N+2.
- Wakeup in cycle M: rdy set at edge M, issue_valid high in cycle M+2. With same-cycle alloc, the wakeup is captured through the bypass.
- Single-cycle issue; throughput of one issue per cycle.
- Full (occupancy=ENTRIES): alloc_ready=0 until the cycle after an issue.
- Empty or no eligible slot: issue_valid=0.

## Configuration
- ISSUE_SCHED_AGE_ORDER_EN defined: an ENTRIES x ENTRIES age matrix is kept, and the oldest eligible slot (earliest allocation) wins. The matrix row/column for a slot is updated on allocation, and the matrix is cleared on flush and reset.
- Not defined: the lowest-index eligible slot wins, and no age state is instantiated.

## Test plan
- Reset, then alloc with both srcs invalid -> alloc_addr=0 during the fire cycle, issue_valid=1 and issue_addr=0 two cycles later, occupancy back to 0.
- Alloc slot 0 waiting on tag 5, alloc slot 1 ready; wakeup tag 5 three cycles later -> slot 1 issues first, slot 0 issues two cycles after the wakeup.
- Alloc waiting on tag 9 in the same cycle wakeup_tag[1]=9 -> slot issues two cycles later; no lost wakeup.
- Fill 64 slots with tag 7 pending -> alloc_ready=0, occupancy=64. Wake tag 7 with issue_stall high for 3 cycles -> no issue. Release the stall -> one issue per cycle. alloc_ready=1 the cycle after the first issue, with alloc_addr equal to the issued slot.
- Flush asserted with 10 valid slots and a simultaneous alloc -> occupancy=0, issue_valid=0 next cycle, allocated slot discarded.
- Age order enabled: alloc into slot 3 then free slot 0 and refill it; both become ready together -> slot 3 issues before slot 0. With the macro undefined -> slot 0 issues first.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// Dispatch / wakeup / issue bundle between the issue scheduler and its neighbours.
// master = dispatch, writeback broadcast and issue consumer side; slave = scheduler.
interface issue_scheduler_if #(
  parameter int ENTRIES      = 64,
  parameter int PHYS_COUNT   = 128,
  parameter int WAKEUP_PORTS = 2
);
  localparam int ADDR_WIDTH      = $clog2(ENTRIES);
  localparam int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT);

  // Handshake: an instruction is accepted in a cycle where alloc_valid and
  // alloc_ready are both high (and clk_en high, flush low); alloc_addr is the
  // slot written. issue_valid is a one-cycle pulse naming issue_addr, suppressed
  // while issue_stall is high. wakeup_valid[p] qualifies wakeup_tag[p] alone.
  logic                                            alloc_valid;
  logic [1:0][PHYS_ADDR_WIDTH-1:0]                 alloc_src_addr;
  logic [1:0]                                      alloc_src_valid;
  logic [1:0]                                      alloc_src_ready;
  logic                                            alloc_ready;
  logic [ADDR_WIDTH-1:0]                           alloc_addr;
  logic [WAKEUP_PORTS-1:0]                         wakeup_valid;
  logic [WAKEUP_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]    wakeup_tag;
  logic                                            issue_stall;
  logic                                            issue_valid;
  logic [ADDR_WIDTH-1:0]                           issue_addr;
  logic [ADDR_WIDTH:0]                             occupancy;

  modport master (
    output alloc_valid, alloc_src_addr, alloc_src_valid, alloc_src_ready,
    output wakeup_valid, wakeup_tag, issue_stall,
    input  alloc_ready, alloc_addr, issue_valid, issue_addr, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_src_addr, alloc_src_valid, alloc_src_ready,
    input  wakeup_valid, wakeup_tag, issue_stall,
    output alloc_ready, alloc_addr, issue_valid, issue_addr, occupancy
  );
endinterface

// File: rtl/issue_scheduler.sv
// Wakeup/select scheduler feeding the instruction queue: allocates slots, tracks
// source readiness, selects one ready slot per cycle. ISSUE_SCHED_AGE_ORDER_EN selects oldest-first.
module issue_scheduler #(
  parameter int ENTRIES      = 64,
  parameter int PHYS_COUNT   = 128,
  parameter int WAKEUP_PORTS = 2
) (
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic               clk_en,
  input  logic               flush,
  issue_scheduler_if.slave   bus
);
  localparam int ADDR_WIDTH      = $clog2(ENTRIES);
  localparam int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT);
  localparam int OCC_W           = ADDR_WIDTH + 1;

  logic [ENTRIES-1:0]                          valid;
  logic [ENTRIES-1:0][1:0][PHYS_ADDR_WIDTH-1:0] tags;
  logic [ENTRIES-1:0][1:0]                     rdy;
  logic                                        issue_valid_q;
  logic [ADDR_WIDTH-1:0]                       issue_addr_q;
  logic [OCC_W-1:0]                            occupancy_q;

  logic                    alloc_found;
  logic [ADDR_WIDTH-1:0]   alloc_slot;
  logic                    alloc_fire;
  logic [1:0]              alloc_bypass;
  logic [ENTRIES-1:0][1:0] wake_hit;
  logic [ENTRIES-1:0]      eligible;
  logic                    sel_found;
  logic [ADDR_WIDTH-1:0]   sel_slot;
  logic                    issue_fire;

  always_comb begin : alloc_pick
    alloc_found = 1'b0;
    alloc_slot  = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (!valid[e]) begin
        alloc_found = 1'b1;
        alloc_slot  = ADDR_WIDTH'(e);
      end
    end
  end

  assign alloc_fire = bus.alloc_valid & alloc_found & clk_en & ~flush;

  // Broadcast tag compare against every stored source and against the incoming
  // sources, so a producer finishing in the allocation cycle is never missed.
  always_comb begin : wake_match
    wake_hit     = '0;
    alloc_bypass = '0;
    for (int p = 0; p < WAKEUP_PORTS; p++) begin
      for (int s = 0; s < 2; s++) begin
        if (bus.wakeup_valid[p] && bus.wakeup_tag[p] == bus.alloc_src_addr[s])
          alloc_bypass[s] = 1'b1;
        for (int e = 0; e < ENTRIES; e++) begin
          if (bus.wakeup_valid[p] && bus.wakeup_tag[p] == tags[e][s])
            wake_hit[e][s] = 1'b1;
        end
      end
    end
  end

  always_comb begin : elig
    for (int e = 0; e < ENTRIES; e++)
      eligible[e] = valid[e] & rdy[e][0] & rdy[e][1];
  end

`ifdef ISSUE_SCHED_AGE_ORDER_EN
  // age[i][j] set means slot i was allocated before slot j.
  logic [ENTRIES-1:0][ENTRIES-1:0] age;

  always_comb begin : select_oldest
    logic blocked;
    blocked   = 1'b0;
    sel_found = 1'b0;
    sel_slot  = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      blocked = 1'b0;
      for (int k = 0; k < ENTRIES; k++) begin
        if (k != e && eligible[k] && age[k][e])
          blocked = 1'b1;
      end
      if (!sel_found && eligible[e] && !blocked) begin
        sel_found = 1'b1;
        sel_slot  = ADDR_WIDTH'(e);
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      age <= '0;
    end else if (clk_en) begin
      if (flush) begin
        age <= '0;
      end else if (alloc_fire) begin
        // A new entry is younger than everything currently present.
        for (int j = 0; j < ENTRIES; j++) begin
          age[alloc_slot][j] <= 1'b0;
          age[j][alloc_slot] <= (ADDR_WIDTH'(j) != alloc_slot);
        end
      end
    end
  end
`else
  always_comb begin : select_lowest
    sel_found = 1'b0;
    sel_slot  = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (eligible[e]) begin
        sel_found = 1'b1;
        sel_slot  = ADDR_WIDTH'(e);
      end
    end
  end
`endif

  assign issue_fire = sel_found & ~bus.issue_stall & clk_en & ~flush;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      valid         <= '0;
      tags          <= '0;
      rdy           <= '0;
      issue_valid_q <= 1'b0;
      issue_addr_q  <= '0;
      occupancy_q   <= '0;
    end else if (clk_en) begin
      if (flush) begin
        valid         <= '0;
        issue_valid_q <= 1'b0;
        occupancy_q   <= '0;
      end else begin
        for (int e = 0; e < ENTRIES; e++) begin
          if (valid[e])
            rdy[e] <= rdy[e] | wake_hit[e];
        end
        if (alloc_fire) begin
          valid[alloc_slot] <= 1'b1;
          tags[alloc_slot]  <= bus.alloc_src_addr;
          rdy[alloc_slot]   <= ~bus.alloc_src_valid | bus.alloc_src_ready | alloc_bypass;
        end
        // The allocated slot is never valid this cycle, so it cannot be sel_slot.
        if (issue_fire) begin
          valid[sel_slot] <= 1'b0;
          issue_valid_q   <= 1'b1;
          issue_addr_q    <= sel_slot;
        end else begin
          issue_valid_q   <= 1'b0;
        end
        case ({alloc_fire, issue_fire})
          2'b10:   occupancy_q <= occupancy_q + OCC_W'(1);
          2'b01:   occupancy_q <= occupancy_q - OCC_W'(1);
          default: occupancy_q <= occupancy_q;
        endcase
      end
    end
  end

  assign bus.alloc_ready = alloc_found;
  assign bus.alloc_addr  = alloc_slot;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_addr  = issue_addr_q;
  assign bus.occupancy   = occupancy_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed scoreboard bench for issue_scheduler: expected {cycle, slot} issues are
// queued by the stimulus and consumed by an independent issue monitor.
module tb_issue_scheduler;
  localparam int ENTRIES = 64;
  localparam int PHYS    = 128;
  localparam int WP      = 2;
  localparam int AW      = 6;
  localparam int PAW     = 7;
  localparam int W       = 32 + AW;

  logic clk = 1'b0;
  logic async_rst_n;
  logic clk_en;
  logic flush;
  logic [31:0] cyc = '0;

  issue_scheduler_if #(.ENTRIES(ENTRIES), .PHYS_COUNT(PHYS), .WAKEUP_PORTS(WP)) bus ();

  issue_scheduler #(.ENTRIES(ENTRIES), .PHYS_COUNT(PHYS), .WAKEUP_PORTS(WP)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .flush       (flush),
    .bus         (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid     = 1'b0;
    bus.alloc_src_valid = 2'b00;
    bus.alloc_src_ready = 2'b00;
    bus.alloc_src_addr  = '0;
    bus.wakeup_valid    = '0;
    bus.wakeup_tag      = '0;
    flush               = 1'b0;
  endtask

  task automatic alloc_set(input logic [1:0] sv, input logic [1:0] sr,
                           input logic [PAW-1:0] t0, input logic [PAW-1:0] t1);
    bus.alloc_valid       = 1'b1;
    bus.alloc_src_valid   = sv;
    bus.alloc_src_ready   = sr;
    bus.alloc_src_addr[0] = t0;
    bus.alloc_src_addr[1] = t1;
  endtask

  task automatic wake_set(input logic v0, input logic [PAW-1:0] t0,
                          input logic v1, input logic [PAW-1:0] t1);
    bus.wakeup_valid  = {v1, v0};
    bus.wakeup_tag[0] = t0;
    bus.wakeup_tag[1] = t1;
  endtask

  task automatic push_exp(input logic [31:0] at, input logic [AW-1:0] slot);
    exp_q.push_back({at, slot});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic [31:0]   e_cyc;
    if (async_rst_n) begin
      if (bus.issue_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_issue: got slot %0d at cycle %0d want no issue", bus.issue_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== {cyc, bus.issue_addr}) begin
            bad++;
            $display("FAIL issue_order: got slot %0d at cycle %0d want slot %0d at cycle %0d",
                     bus.issue_addr, cyc, e[AW-1:0], e[W-1:AW]);
          end
        end
      end else if (exp_q.size() != 0) begin
        e     = exp_q[0];
        e_cyc = e[W-1:AW];
        if (e_cyc <= cyc) begin
          total++;
          bad++;
          $display("FAIL missing_issue: got no issue at cycle %0d want slot %0d", cyc, e[AW-1:0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    async_rst_n     = 1'b0;
    clk_en          = 1'b1;
    bus.issue_stall = 1'b0;
    idle();
    repeat (3) step();
    async_rst_n = 1'b1;
    step();

    // reset state
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_alloc_addr",  bus.alloc_addr, 0);
    check("rst_occupancy",   bus.occupancy, 0);
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_issue_addr",  bus.issue_addr, 0);

    // single instruction, no sources
    alloc_set(2'b00, 2'b00, 7'd0, 7'd0);
    check("t1_alloc_addr", bus.alloc_addr, 0);
    push_exp(cyc + 2, 6'd0);
    step();
    idle();
    check("t1_occ_one", bus.occupancy, 1);
    step();
    check("t1_occ_zero", bus.occupancy, 0);
    repeat (3) step();

    // slot 0 waits on tag 5 (src1), slot 1 ready; wake tag 5 three cycles after first alloc
    alloc_set(2'b11, 2'b01, 7'd2, 7'd5);
    check("t2_alloc_addr0", bus.alloc_addr, 0);
    step();
    alloc_set(2'b00, 2'b00, 7'd0, 7'd0);
    check("t2_alloc_addr1", bus.alloc_addr, 1);
    push_exp(cyc + 2, 6'd1);
    step();
    idle();
    step();
    wake_set(1'b1, 7'd5, 1'b0, 7'd0);
    push_exp(cyc + 2, 6'd0);
    step();
    idle();
    repeat (5) step();
    check("t2_occ_zero", bus.occupancy, 0);

    // same-cycle wakeup bypass on port 1
    alloc_set(2'b11, 2'b10, 7'd9, 7'd20);
    wake_set(1'b1, 7'd8, 1'b1, 7'd9);
    check("t3_alloc_addr", bus.alloc_addr, 0);
    push_exp(cyc + 2, 6'd0);
    step();
    idle();
    repeat (4) step();

    // clk_en low blocks allocation
    clk_en = 1'b0;
    alloc_set(2'b00, 2'b00, 7'd0, 7'd0);
    step();
    idle();
    check("t4_gated_occ", bus.occupancy, 0);
    check("t4_gated_addr", bus.alloc_addr, 0);
    clk_en = 1'b1;
    step();

    // fill every slot waiting on tag 7
    for (int i = 0; i < ENTRIES; i++) begin
      alloc_set(2'b01, 2'b00, 7'd7, 7'd0);
      if (i == 0 || i == 31 || i == 63) check("t5_fill_addr", bus.alloc_addr, i);
      step();
    end
    idle();
    check("t5_full_ready", bus.alloc_ready, 0);
    check("t5_full_occ", bus.occupancy, 64);
    bus.issue_stall = 1'b1;
    wake_set(1'b1, 7'd7, 1'b0, 7'd0);
    step();
    idle();
    repeat (2) step();
    check("t5_stall_occ", bus.occupancy, 64);
    bus.issue_stall = 1'b0;
    for (int i = 0; i < ENTRIES; i++) push_exp(cyc + 1 + i, AW'(i));
    check("t5_release_ready", bus.alloc_ready, 0);
    step();
    check("t5_freed_ready", bus.alloc_ready, 1);
    check("t5_freed_addr", bus.alloc_addr, 0);
    repeat (66) step();
    check("t5_drain_occ", bus.occupancy, 0);

    // flush with ten pending slots and a simultaneous ready alloc
    for (int i = 0; i < 10; i++) begin
      alloc_set(2'b10, 2'b00, 7'd0, 7'd30);
      step();
    end
    idle();
    check("t6_pre_occ", bus.occupancy, 10);
    flush = 1'b1;
    alloc_set(2'b00, 2'b00, 7'd0, 7'd0);
    wake_set(1'b1, 7'd30, 1'b0, 7'd0);
    step();
    idle();
    check("t6_flush_occ", bus.occupancy, 0);
    check("t6_flush_iv", bus.issue_valid, 0);
    check("t6_flush_addr", bus.alloc_addr, 0);
    wake_set(1'b1, 7'd30, 1'b1, 7'd30);
    step();
    idle();
    repeat (4) step();
    check("t6_post_occ", bus.occupancy, 0);

    // age order: slot 3 allocated before refilled slot 0
    alloc_set(2'b01, 2'b00, 7'd41, 7'd0);
    step();
    alloc_set(2'b01, 2'b00, 7'd42, 7'd0);
    step();
    alloc_set(2'b01, 2'b00, 7'd42, 7'd0);
    step();
    alloc_set(2'b01, 2'b00, 7'd40, 7'd0);
    check("t7_alloc_addr3", bus.alloc_addr, 3);
    step();
    idle();
    wake_set(1'b1, 7'd41, 1'b0, 7'd0);
    push_exp(cyc + 2, 6'd0);
    step();
    idle();
    step();
    check("t7_refill_addr", bus.alloc_addr, 0);
    alloc_set(2'b01, 2'b00, 7'd40, 7'd0);
    step();
    idle();
    wake_set(1'b0, 7'd0, 1'b1, 7'd40);
`ifdef ISSUE_SCHED_AGE_ORDER_EN
    push_exp(cyc + 2, 6'd3);
    push_exp(cyc + 3, 6'd0);
`else
    push_exp(cyc + 2, 6'd0);
    push_exp(cyc + 3, 6'd3);
`endif
    step();
    idle();
    repeat (4) step();
    wake_set(1'b1, 7'd42, 1'b0, 7'd0);
    push_exp(cyc + 2, 6'd1);
    push_exp(cyc + 3, 6'd2);
    step();
    idle();
    repeat (5) step();
    check("t7_final_occ", bus.occupancy, 0);

    // final report
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
